// File: rtl/bsearch_pkg.sv
// Shared constants and types for the binary-search datapath and its controller.
package bsearch_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 4;

    // Width of low/high: one extra bit for DEPTH, one for the sign of -1.
    localparam int unsigned IDX_W_DEF = ADDR_W_DEF + 2;

    localparam logic [2:0] EQZ_LT = 3'b100;
    localparam logic [2:0] EQZ_EQ = 3'b010;
    localparam logic [2:0] EQZ_GT = 3'b001;

    typedef logic signed [IDX_W_DEF-1:0] idx_t;

endpackage

// File: rtl/bsearch_datapath_if.sv
// Controller strobes, table write port and search-result signals of the datapath.
interface bsearch_datapath_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);

    logic              ld1;
    logic              ld2;
    logic              ld4;
    logic              ld5;
    logic              ld6;
    logic              ld7;
    logic              c1;
    logic              c2;
    logic              done;
    logic [DATA_W-1:0] key_in;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        eqz;
    logic              signal;
    logic              result_valid;
    logic              result_found;
    logic [ADDR_W-1:0] result_idx;
    logic [ADDR_W:0]   probe_count;

    modport master (
        output ld1, ld2, ld4, ld5, ld6, ld7, c1, c2, done, key_in,
        output wr_en, wr_addr, wr_data,
        input  eqz, signal, result_valid, result_found, result_idx, probe_count
    );

    modport slave (
        input  ld1, ld2, ld4, ld5, ld6, ld7, c1, c2, done, key_in,
        input  wr_en, wr_addr, wr_data,
        output eqz, signal, result_valid, result_found, result_idx, probe_count
    );

endinterface

// File: rtl/bsearch_table.sv
// Sorted lookup table: single write port, registered read with read-before-write.
module bsearch_table #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register samples the pre-edge array contents, so a colliding write is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/bsearch_datapath.sv
// Binary-search datapath: interval registers, probe compare, result capture.
module bsearch_datapath
    import bsearch_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
    input  logic clk,
    input  logic rst_n,
    bsearch_datapath_if.slave bus
);

    localparam int unsigned IW = ADDR_W + 2;

    logic signed [IW-1:0] low_q, low_d;
    logic signed [IW-1:0] high_q, high_d;
    logic signed [IW:0]   sum;
    logic [ADDR_W-1:0]    mid_q, mid_d;
    logic [DATA_W-1:0]    r5;
    logic [DATA_W-1:0]    n_q;
    logic [ADDR_W:0]      probe_q;
    logic                 done_q;
    logic                 found_q;
    logic [ADDR_W-1:0]    idx_q;
    logic [2:0]           eqz_c;
    logic                 signal_c;
    logic                 search_init;
    logic                 result_pulse;

    assign search_init  = bus.ld1 & ~bus.c1;
    assign result_pulse = bus.done & ~done_q;

    always_comb begin
        low_d  = low_q;
        high_d = high_q;
        mid_d  = mid_q;
        sum    = (IW + 1)'(low_q) + (IW + 1)'(high_q);
        if (bus.ld1) begin
            low_d = bus.c1 ? IW'(mid_q) + IW'(1) : '0;
        end
        if (bus.ld2) begin
            high_d = bus.c2 ? IW'(mid_q) - IW'(1) : IW'(DEPTH - 1);
        end
        if (bus.ld4) begin
            mid_d = ADDR_W'(sum >>> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_q  <= '0;
            high_q <= '0;
            mid_q  <= '0;
            n_q    <= '0;
            done_q <= 1'b0;
        end else begin
            low_q  <= low_d;
            high_q <= high_d;
            mid_q  <= mid_d;
            done_q <= bus.done;
            if (bus.ld6) begin
                n_q <= bus.key_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            probe_q <= '0;
        end else if (search_init) begin
            probe_q <= '0;
        end else if (bus.ld7 && (probe_q != '1)) begin
            probe_q <= probe_q + 1'b1;
        end
    end

    // Capture wins over a coincident init; otherwise init clears the previous result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            found_q <= 1'b0;
            idx_q   <= '0;
        end else if (result_pulse) begin
            found_q <= eqz_c[1] & ~signal_c;
            idx_q   <= mid_q;
        end else if (search_init) begin
            found_q <= 1'b0;
            idx_q   <= '0;
        end
    end

    bsearch_table #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_table (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (bus.wr_en),
        .wr_addr(bus.wr_addr),
        .wr_data(bus.wr_data),
        .rd_en  (bus.ld5),
        .rd_addr(mid_q),
        .rd_data(r5)
    );

    always_comb begin
        eqz_c = EQZ_EQ;
        if (r5 < n_q) begin
            eqz_c = EQZ_LT;
        end else if (r5 > n_q) begin
            eqz_c = EQZ_GT;
        end
    end

    assign signal_c = low_q > high_q;

    assign bus.eqz          = eqz_c;
    assign bus.signal       = signal_c;
    assign bus.result_valid = result_pulse;
    assign bus.result_found = found_q;
    assign bus.result_idx   = idx_q;
    assign bus.probe_count  = probe_q;

endmodule

// File: doc/bsearch_datapath.md
Name: bsearch_datapath

Overview:
- Datapath that pairs with the binary-search controller FSM. It executes the controller's load and select strobes (ld1, ld2, ld4, ld5, ld6, ld7, c1, c2) on a sorted on-chip array.
- It returns the comparison flags (eqz) and the interval-exhausted flag (signal) that steer the FSM.
- It holds the sorted table with a host write port and registers the search result when the controller raises done.

Parameters:
- DATA_W, 8, width of table entries and search key
- ADDR_W, 4, table index width
- DEPTH, 16, number of entries (must equal 2**ADDR_W)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ld1  input  1  load low register
- ld2  input  1  load high register
- ld4  input  1  load mid register
- ld5  input  1  load data register R5 from table[mid]
- ld6  input  1  latch key_in into key register N
- ld7  input  1  increment probe counter
- c1  input  1  low source select: 0 = 0, 1 = mid+1
- c2  input  1  high source select: 0 = DEPTH-1, 1 = mid-1
- done  input  1  controller done
- key_in  input  DATA_W  search key
- wr_en  input  1  table write strobe
- wr_addr  input  ADDR_W  table write index
- wr_data  input  DATA_W  table write data
- eqz  output  3  {R5<N, R5==N, R5>N}, one-hot
- signal  output  1  low > high (interval empty)
- result_valid  output  1  one-cycle pulse on first done cycle
- result_found  output  1  key found
- result_idx  output  ADDR_W  index of match (last mid on miss)
- probe_count  output  ADDR_W+1  probes performed

Behaviour:
- Reset is asynchronous on rst_n low. It clears:
  - low, high, mid, R5, N, probe_count, result_* and the done-delay flop.
  - The table is not reset.
- low and high are signed, ADDR_W+2 bits wide, so that low=DEPTH and high=-1 represent without wrap.
- mid is ADDR_W bits wide.
- Register updates, all on the rising clk edge:
  - ld1: low <= c1 ? mid+1 : 0.
  - ld2: high <= c2 ? mid-1 : DEPTH-1.
  - ld1 and ld2 are independent and may assert together.
- ld4: mid <= (low+high)>>>1, truncated to ADDR_W. The controller only asserts ld4 while low<=high.
- ld5: R5 <= table[mid] using the mid value registered before this edge. This is a synchronous read, so ld5 must follow ld4 by at least one cycle.
- ld6: N <= key_in.
- ld7: probe_count <= probe_count+1, saturating at all-ones.
- probe_count is cleared on any edge with ld1 & ~c1 (search init). Clear takes priority over increment.
- eqz is combinational from R5 and N, unsigned compare, always exactly one bit set. After reset R5=N=0, so eqz=3'b010.
- signal is combinational: low > high (signed).
- Table writes occur when wr_en is high: table[wr_addr] <= wr_data.
- Write and ld5 to the same address in the same cycle: R5 gets the old data (read-before-write).
- Writes during an active search are legal. Result correctness is then undefined; no error flag.
- Result capture: done_q is done delayed by one cycle.
  - result_valid = done & ~done_q (one cycle).
  - On that edge: result_found <= eqz[1] & ~signal; result_idx <= mid; probe_count is frozen by the absence of ld7.
  - result_found, result_idx and probe_count hold until the next search init or reset.
- Simultaneous ld1/ld2 with ld4: ld4 uses the pre-edge low/high.
- Reset mid-search returns all registers to reset values immediately. There is no result pulse.

Decomposition:
- Shared package (bsearch_pkg):
  - EQZ_LT=3'b100, EQZ_EQ=3'b010, EQZ_GT=3'b001 constants, shared with the controller.
  - DATA_W/ADDR_W defaults.
  - Index type width ADDR_W+2 for low/high.
- One natural sub-module: bsearch_table, the DEPTH x DATA_W synchronous-read, single-write memory with read-before-write.

Test Plan:
- Reset, then fill table[i]=2*i for i=0..15. Key 14, drive controller sequence:
  - first probe mid=7, eqz=010.
  - result_valid pulse, result_found=1, result_idx=7, probe_count=1.
- Key 4:
  - mids visited 7, 3, 1, 2.
  - eqz sequence 001, 001, 100, 010.
  - result_found=1, result_idx=2, probe_count=4.
- Key 5:
  - after mid=2 (eqz=100), low=3, high=2, signal=1.
  - result_found=0, probe_count=4.
- Key 31 (upper boundary):
  - mids 7, 11, 13, 14, 15; final low=16, high=15, no wrap.
  - signal=1, result_found=0, probe_count=5.
- Key 0 (lower boundary):
  - mids 7, 3, 1, 0, with the final compare finding table[0]=0 (eqz=010).
  - result_found=1, result_idx=0, probe_count=4.
  - A follow-up search for an absent key below table[0] (set table[0]=2, key 1) must give high=-1 and signal=1, with no wrap to 63.
- Assert rst_n low for 1 cycle mid-search (after 2 probes):
  - all outputs return to zero asynchronously and eqz=010.
  - no result_valid pulse.
  - a new search after release completes correctly.
